// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: instruction memory,
// hazard unit, ID (jumps) and EX (branches). The fetch stage uses the slave side.
interface if_stage_if;
    logic [31:0] instr_in;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] fetch_pc;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;

    modport master (
        output instr_in, stall, branch_taken, branch_target, jump, jump_index,
        input  fetch_pc, instr_id, pc4_id, valid_id
    );

    modport slave (
        input  instr_in, stall, branch_taken, branch_target, jump, jump_index,
        output fetch_pc, instr_id, pc4_id, valid_id
    );
endinterface

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: drives the synchronous instruction memory
// address, tracks the PC of the word it returns, and owns the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    if_stage_if.slave      io_fetch
);

    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc4_id;
    logic        r_valid_id;

    logic [31:0] w_fetch_pc;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_squash;

    assign w_jump_target   = {r_pc4_id[31:28], io_fetch.jump_index, 2'b00};
    assign w_branch_target = io_fetch.branch_target & 32'hFFFF_FFFC;

    // A stall re-fetches the word already in flight so instr_in stays stable.
    always_comb begin
        w_fetch_pc = r_pc;
        if (reset) begin
            w_fetch_pc = RESET_PC;
        end else if (io_fetch.branch_taken) begin
            w_fetch_pc = w_branch_target;
        end else if (io_fetch.stall) begin
            w_fetch_pc = r_if_pc;
        end else if (io_fetch.jump) begin
            w_fetch_pc = w_jump_target;
        end
    end

    // A stall holds ID, so a jump waiting in ID is only acted on once it drops.
    assign w_squash = io_fetch.branch_taken || (!io_fetch.stall && io_fetch.jump);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_if_pc    <= RESET_PC;
            r_if_valid <= 1'b0;
        end else begin
            r_pc       <= w_fetch_pc + 32'd4;
            r_if_pc    <= w_fetch_pc;
            r_if_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_id <= NOP_WORD;
            r_pc4_id   <= 32'd0;
            r_valid_id <= 1'b0;
        end else if (w_squash) begin
            r_instr_id <= NOP_WORD;
            r_pc4_id   <= 32'd0;
            r_valid_id <= 1'b0;
        end else if (!io_fetch.stall) begin
            r_instr_id <= r_if_valid ? io_fetch.instr_in : NOP_WORD;
            r_pc4_id   <= r_if_pc + 32'd4;
            r_valid_id <= r_if_valid;
        end
    end

    assign io_fetch.fetch_pc = w_fetch_pc;
    assign io_fetch.instr_id = r_instr_id;
    assign io_fetch.pc4_id   = r_pc4_id;
    assign io_fetch.valid_id = r_valid_id;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a directed vector table walking the fetch scenarios,
// then random control traffic compared against an address-level pipeline model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        jmp;
        logic [25:0] idx;
        logic [31:0] expFetch;
        logic [31:0] expInstr;
        logic [31:0] expPc4;
        logic        expValid;
    } vecT;

    // What the model knows: next sequential address, address of the word on the
    // memory output, and which fetched address (if any) sits in ID.
    typedef struct {
        logic [31:0] nextPc;
        logic [31:0] memPc;
        logic        memValid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } modelT;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   checks = 0;
    vecT  dirVec[$];

    if_stage_if bus();

    if_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk      (clk),
        .reset    (reset),
        .io_fetch (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [7:0] a);
        case (a)
            8'd0:    return 32'h2001_0004;
            8'd1:    return 32'h2022_0002;
            8'd2:    return 32'h0001_1820;
            8'd9:    return 32'h0800_0005;
            default: return {24'hAC0000, a};
        endcase
    endfunction

    // Synchronous instruction memory, 256 words.
    always @(posedge clk) bus.instr_in <= romWord(bus.fetch_pc[9:2]);

    function automatic vecT mk(input logic rst, input logic stall, input logic br,
                               input logic [31:0] tgt, input logic jmp, input logic [25:0] idx,
                               input logic [31:0] eF, input logic [31:0] eI,
                               input logic [31:0] eP, input logic eV);
        vecT v;
        v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.jmp = jmp; v.idx = idx;
        v.expFetch = eF; v.expInstr = eI; v.expPc4 = eP; v.expValid = eV;
        return v;
    endfunction

    function automatic logic [31:0] modelFetch(input modelT m, input vecT v);
        if (v.rst)   return RESET_PC;
        if (v.br)    return {v.tgt[31:2], 2'b00};
        if (v.stall) return m.memPc;
        if (v.jmp)   return {m.pc4[31:28], v.idx, 2'b00};
        return m.nextPc;
    endfunction

    function automatic modelT modelEdge(input modelT m, input vecT v, input logic [31:0] f);
        modelT n = m;
        if (v.rst) begin
            n.nextPc = RESET_PC; n.memPc = RESET_PC; n.memValid = 1'b0;
            n.instr = NOP_WORD; n.pc4 = 32'd0; n.valid = 1'b0;
            return n;
        end
        n.memPc = f;
        n.nextPc = f + 32'd4;
        n.memValid = 1'b1;
        if (v.br || (v.jmp && !v.stall)) begin
            n.instr = NOP_WORD; n.pc4 = 32'd0; n.valid = 1'b0;
        end else if (!v.stall) begin
            n.instr = m.memValid ? romWord(m.memPc[9:2]) : NOP_WORD;
            n.pc4 = m.memPc + 32'd4;
            n.valid = m.memValid;
        end
        return n;
    endfunction

    task automatic applyStimulus(input vecT v);
        reset             = v.rst;
        bus.stall         = v.stall;
        bus.branch_taken  = v.br;
        bus.branch_target = v.tgt;
        bus.jump          = v.jmp;
        bus.jump_index    = v.idx;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic runVector(input vecT v, input string tag);
        applyStimulus(v);
        #2;
        checkOutput({tag, " fetch_pc"}, bus.fetch_pc, v.expFetch);
        @(posedge clk);
        #1;
        checkOutput({tag, " instr_id"}, bus.instr_id, v.expInstr);
        checkOutput({tag, " pc4_id"}, bus.pc4_id, v.expPc4);
        checkOutput({tag, " valid_id"}, {31'd0, bus.valid_id}, {31'd0, v.expValid});
        vectors++;
    endtask

    initial begin
        modelT m;
        vecT   v;
        logic [31:0] f;

        // Reset, sequential fetch, 3-cycle stall with rom[2] in ID.
        dirVec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h00, NOP_WORD, 32'h00, 0));
        dirVec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h00, NOP_WORD, 32'h00, 0));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h00, NOP_WORD, 32'h04, 0));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h04, romWord(0), 32'h04, 1));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h08, romWord(1), 32'h08, 1));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0C, romWord(2), 32'h0C, 1));
        for (int k = 0; k < 3; k++)
            dirVec.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0C, romWord(2), 32'h0C, 1));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h10, romWord(3), 32'h10, 1));
        for (int k = 5; k <= 10; k++)
            dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'(4 * k), romWord(8'(k - 1)), 32'(4 * k), 1));
        // Jump from 0x24 to word 5; then branch overriding stall and jump.
        dirVec.push_back(mk(0, 0, 0, 0, 1, 26'd5, 32'h14, NOP_WORD, 32'h00, 0));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h18, romWord(5), 32'h18, 1));
        dirVec.push_back(mk(0, 1, 1, 32'h13, 1, 26'd7, 32'h10, NOP_WORD, 32'h00, 0));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h14, romWord(4), 32'h14, 1));
        // Address wrap from the top word.
        dirVec.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, NOP_WORD, 32'h00, 0));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h00, romWord(8'hFF), 32'h00, 1));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h04, romWord(0), 32'h04, 1));
        // Reset during a stall.
        dirVec.push_back(mk(0, 1, 0, 0, 0, 0, 32'h04, romWord(0), 32'h04, 1));
        dirVec.push_back(mk(1, 1, 0, 0, 0, 0, 32'h00, NOP_WORD, 32'h00, 0));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h00, NOP_WORD, 32'h04, 0));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h04, romWord(0), 32'h04, 1));
        // Jump held under stall, taken once the stall drops.
        dirVec.push_back(mk(0, 1, 0, 0, 1, 26'd3, 32'h04, romWord(0), 32'h04, 1));
        dirVec.push_back(mk(0, 0, 0, 0, 1, 26'd3, 32'h0C, NOP_WORD, 32'h00, 0));
        dirVec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h10, romWord(3), 32'h10, 1));

        foreach (dirVec[i]) runVector(dirVec[i], $sformatf("dir%0d", i));

        m = '{default: '0};
        for (int i = 0; i < 400; i++) begin
            v.rst   = (i == 0) || ($urandom_range(0, 29) == 0);
            v.stall = ($urandom_range(0, 3) == 0);
            v.br    = ($urandom_range(0, 7) == 0);
            v.tgt   = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
            v.jmp   = ($urandom_range(0, 5) == 0);
            v.idx   = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(0, 255));
            f = modelFetch(m, v);
            m = modelEdge(m, v, f);
            v.expFetch = f;
            v.expInstr = m.instr;
            v.expPc4   = m.pc4;
            v.expValid = m.valid;
            runVector(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch front end of the MIPS32 pipeline.
- Generates the fetch address for the synchronous instruction memory and tracks which PC that memory's registered output belongs to.
- Owns the IF/ID pipeline register that feeds decode.
- Handles load-use stalls, jump redirects from ID and taken-branch redirects from EX, squashing wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.
NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
instr_in  in  32  instruction memory output: word at if_pc, valid one edge after fetch_pc is sampled.
stall  in  1  hazard unit: hold IF and ID contents.
branch_taken  in  1  EX: branch resolved taken.
branch_target  in  32  EX: branch destination byte address.
jump  in  1  ID: instruction in ID is j.
jump_index  in  26  ID: instr_id[25:0].
fetch_pc  out  32  combinational address to instruction memory pc input.
instr_id  out  32  IF/ID instruction.
pc4_id  out  32  IF/ID PC+4 of instr_id.
valid_id  out  1  instr_id is a real fetched instruction, not a bubble.

Behaviour:
- Internal registers:
  - pc_q: next sequential fetch address.
  - if_pc_q: address of the word currently on instr_in.
  - if_valid_q.
  - IF/ID registers instr_id, pc4_id, valid_id.
- Jump target: {pc4_id[31:28], jump_index, 2'b00}.
- fetch_pc mux, strict priority:
  - reset: RESET_PC
  - branch_taken: {branch_target[31:2], 2'b00}
  - stall: if_pc_q (re-fetch the same word so instr_in stays stable)
  - jump: jump target
  - otherwise: pc_q
- Every edge:
  - reset=1: pc_q, if_pc_q <= RESET_PC; if_valid_q, valid_id <= 0; instr_id <= NOP_WORD; pc4_id <= 0.
  - reset=0: if_pc_q <= fetch_pc; pc_q <= fetch_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0); if_valid_q <= 1.
- IF/ID update, reset=0, same priority order:
  - branch_taken: squash. instr_id <= NOP_WORD, valid_id <= 0, pc4_id <= 0. Killing the instruction already in ID belongs to ID/EX, not this block.
  - stall (no branch): instr_id, pc4_id, valid_id hold.
  - jump (no branch, no stall): squash as for branch. No delay slot.
  - otherwise: instr_id <= if_valid_q ? instr_in : NOP_WORD; pc4_id <= if_pc_q + 4; valid_id <= if_valid_q.
- Latency:
  - fetch_pc sampled at edge N; word appears on instr_in after N and reaches instr_id at edge N+1.
  - First instruction after reset release reaches ID at the 2nd edge.
- Redirect penalty:
  - Jump: 1 bubble.
  - Branch: 1 bubble in ID, plus the ID/EX kill handled downstream.
- Simultaneous events:
  - branch_taken overrides stall and jump.
  - stall overrides jump; jump is acted on once stall drops, since ID still holds the jump.
- Reset mid-stall or mid-redirect: reset wins; fetch_pc = RESET_PC combinationally in the same cycle.
- No other outputs are combinational; no X on any output after the first reset edge.

Test Plan:
- Run from reset. ROM: rom[0]=0x20010004, rom[1]=0x20220002, rom[2]=0x00011820.
  - Release reset.
  - 2nd edge: instr_id=0x20010004, pc4_id=4, valid_id=1.
  - 3rd edge: 0x20220002, pc4_id=8. fetch_pc sequence: 0, 4, 8, C.
- Stall 3 cycles while ID holds rom[2] (pc4_id=0x0C).
  - fetch_pc=0x0C each stall cycle; instr_id and pc4_id constant.
  - After release: rom[3] with pc4_id=0x10; no duplicated or skipped word.
- jump=1, jump_index=5, ID holding 0x08000005 at address 0x24.
  - fetch_pc=0x14 in the same cycle.
  - Next edge: instr_id=0, valid_id=0.
  - Following edge: instr_id=rom[5], pc4_id=0x18.
- branch_taken=1, branch_target=0x13, with stall=1 and jump=1 in the same cycle.
  - fetch_pc=0x10.
  - Next edge: bubble (valid_id=0).
  - Then instr_id=rom[4], pc4_id=0x14.
- Force pc_q=0xFFFFFFFC via branch target 0xFFFFFFFC: subsequent fetch_pc=0x00000000 (wrap).
- Assert reset during a stall: fetch_pc=RESET_PC immediately; after the edge valid_id=0, instr_id=0, pc4_id=0; fetch restarts at 0.
